cache_axi_bridge_mp: RTL and testbench

//  Parametrised cache-to-AXI3 bridge. NUM_RD cache read ports share one AR/R path, with round-robin arbitration
//  and up to MAX_OUT outstanding reads routed back by rid. One write port has a line buffer and issues single or

---
 rtl/cache_axi_pkg.sv | 17 +
 rtl/cache_axi_bridge_mp_rr_arbiter.sv | 37 +++
 rtl/cache_axi_bridge_mp.sv | 237 +++++++++++++++++++++++
 tb/tb_cache_axi_bridge_mp.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// Shared constants, FSM state types and the line-address helper for the cache/AXI bridge.
package cache_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE   = 3'b100;

  typedef enum logic {AR_IDLE, AR_VALID} ar_state_t;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  // Cache line number of a byte address; shift = log2(bytes per line).
  function automatic logic [63:0] line_of(input logic [63:0] addr, input int shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at a registered pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  int            win;
  int            idx;

  // Scan from ptr+N-1 down to ptr so the requester closest to ptr wins last.
  always_comb begin
    grant = '0;
    win   = 0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) win = idx;
    end
    if (|req) grant[win] = 1'b1;
  end

  // Once a grant is taken the winner drops to lowest priority; nothing else
  // arbitrates until the AR handshake, so this matches moving on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= PW'((win + 1) % N);
  end

endmodule

// File: rtl/cache_axi_bridge_mp.sv
// Cache-to-AXI3 bridge: NUM_RD read ports sharing AR/R, one buffered write port on AW/W/B.
module cache_axi_bridge_mp
  import cache_axi_pkg::*;
#(
  parameter int NUM_RD     = 2,
  parameter int LINE_WORDS = 4,
  parameter int MAX_OUT    = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [3*NUM_RD-1:0]          rd_type,
  input  logic [ADDR_W*NUM_RD-1:0]     rd_addr,
  output logic [NUM_RD-1:0]            rd_rdy,
  output logic [NUM_RD-1:0]            ret_valid,
  output logic [NUM_RD-1:0]            ret_last,
  output logic [DATA_W-1:0]            ret_data,
  input  logic                         wr_req,
  input  logic [2:0]                   wr_type,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [3:0]                   wr_wstrb,
  input  logic [DATA_W*LINE_WORDS-1:0] wr_data,
  output logic                         wr_rdy,
  output logic                         wr_done,
  output logic [3:0]                   arid,
  output logic [ADDR_W-1:0]            araddr,
  output logic [3:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [1:0]                   arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  output logic [3:0]                   awid,
  output logic [ADDR_W-1:0]            awaddr,
  output logic [3:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic [1:0]                   awlock,
  output logic [3:0]                   awcache,
  output logic [2:0]                   awprot,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [3:0]                   wid,
  output logic [DATA_W-1:0]            wdata,
  output logic [3:0]                   wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [3:0]                   bid,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready
);

  localparam int         LINE_SHIFT = $clog2(LINE_WORDS * 4);
  localparam logic [3:0] LINE_LEN   = 4'(LINE_WORDS - 1);

  ar_state_t                   ar_state, ar_next;
  w_state_t                    w_state, w_next;
  logic [NUM_RD-1:0]           hazard, arb_req, grant;
  logic                        ar_take, ar_hs, r_end, wr_accept, aw_hs, w_hs;
  logic                        aw_done, w_done;
  logic [2:0]                  outstanding;
  logic [3:0]                  beat;
  logic [DATA_W*LINE_WORDS-1:0] wbuf;
  int                          gidx;
  logic                        unused_ok;

  assign unused_ok = ^{rresp, bresp, bid};

  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awid    = '0;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = '0;

  assign wr_accept = wr_req & wr_rdy;
  assign ar_hs     = arvalid & arready;
  assign r_end     = rvalid & rready & rlast;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;

  // Block reads whose line matches the write being sent or being accepted now.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      hazard[i] =
        ((w_state != W_IDLE) &&
         (line_of(64'(rd_addr[i*ADDR_W +: ADDR_W]), LINE_SHIFT) == line_of(64'(awaddr), LINE_SHIFT))) ||
        (wr_accept &&
         (line_of(64'(rd_addr[i*ADDR_W +: ADDR_W]), LINE_SHIFT) == line_of(64'(wr_addr), LINE_SHIFT)));
    end
  end

  assign arb_req = ((ar_state == AR_IDLE) && (outstanding < 3'(MAX_OUT))) ? (rd_req & ~hazard) : '0;
  assign ar_take = |grant;

  rr_arbiter #(.N(NUM_RD)) u_arb (
    .clk     (aclk),
    .rst     (areset),
    .req     (arb_req),
    .advance (ar_take),
    .grant   (grant)
  );

  // One-hot grant to port index.
  always_comb begin
    gidx = 0;
    for (int i = 0; i < NUM_RD; i++) if (grant[i]) gidx = i;
  end

  // AR state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ar_state <= AR_IDLE;
    else        ar_state <= ar_next;
  end

  // AR next state: hold the request until the slave takes it.
  always_comb begin
    ar_next = ar_state;
    case (ar_state)
      AR_IDLE:  if (ar_take) ar_next = AR_VALID;
      AR_VALID: if (arready) ar_next = AR_IDLE;
      default:  ar_next = AR_IDLE;
    endcase
  end

  // AR outputs.
  always_comb begin
    arvalid = (ar_state == AR_VALID);
  end

  // Capture the granted port's request fields.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arid   <= '0;
      araddr <= '0;
      arlen  <= '0;
    end else if (ar_take) begin
      arid   <= 4'(gidx);
      araddr <= rd_addr[gidx*ADDR_W +: ADDR_W];
      arlen  <= (rd_type[gidx*3 +: 3] == RD_TYPE_LINE) ? LINE_LEN : 4'd0;
    end
  end

  // Outstanding reads: one per AR handshake, retired by the closing R beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)               outstanding <= '0;
    else if (ar_hs && !r_end) outstanding <= outstanding + 3'd1;
    else if (!ar_hs && r_end) outstanding <= outstanding - 3'd1;
  end

  // Read return routing by rid; no buffering so R beats go straight out.
  always_comb begin
    rready   = (outstanding != 3'd0);
    ret_data = rdata;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_rdy[i]    = ar_hs && (arid == 4'(i));
      ret_valid[i] = rvalid && rready && (rid == 4'(i));
      ret_last[i]  = ret_valid[i] && rlast;
    end
  end

  // W state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // W next state: leave W_SEND once both AW and the last W beat are done.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (wr_accept) w_next = W_SEND;
      W_SEND: if ((aw_done || aw_hs) && (w_done || (w_hs && wlast))) w_next = W_RESP;
      W_RESP: if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // W outputs.
  always_comb begin
    wr_rdy  = (w_state == W_IDLE);
    awvalid = (w_state == W_SEND) && !aw_done;
    wvalid  = (w_state == W_SEND) && !w_done;
    bready  = (w_state == W_RESP);
    wr_done = (w_state == W_RESP) && bvalid;
    wdata   = wbuf[DATA_W-1:0];
    wlast   = (beat == awlen);
  end

  // Write datapath: latch on accept, shift one word per W beat, track channel completion.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awaddr  <= '0;
      awlen   <= '0;
      wstrb   <= '0;
      wbuf    <= '0;
      beat    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_accept) begin
      awaddr  <= wr_addr;
      awlen   <= (wr_type == RD_TYPE_LINE) ? LINE_LEN : 4'd0;
      wstrb   <= (wr_type == RD_TYPE_LINE) ? 4'hf : wr_wstrb;
      wbuf    <= wr_data;
      beat    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (w_state == W_SEND) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) begin
        wbuf <= wbuf >> DATA_W;
        beat <= beat + 4'd1;
        if (wlast) w_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge_mp.sv
// Directed bench for cache_axi_bridge_mp: R-beat table plus hand sequences for arbitration, limits, writes, hazard and reset.
module tb_cache_axi_bridge_mp;

  logic         aclk = 1'b0;
  logic         areset;
  logic [1:0]   rd_req;
  logic [5:0]   rd_type;
  logic [63:0]  rd_addr;
  logic [1:0]   rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy, wr_done;
  logic [3:0]   arid, arlen, arcache;
  logic [31:0]  araddr;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, arlock;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic [3:0]   awid, awlen, awcache;
  logic [31:0]  awaddr;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst, awlock;
  logic         awvalid, awready;
  logic [3:0]   wid, wstrb;
  logic [31:0]  wdata;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  int checks = 0;
  int errors = 0;

  cache_axi_bridge_mp dut (
    .aclk(aclk), .areset(areset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic [1:0]  exp_valid;
    logic [1:0]  exp_last;
    logic        exp_rready;
  } rvec_t;

  rvec_t rv[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Request one read on a port, wait for its AR, check fields and take it.
  task automatic issue_ar(input int port, input logic [31:0] addr, input logic [2:0] typ,
                          input logic [3:0] exp_len);
    int n;
    rd_addr[port*32 +: 32] = addr;
    rd_type[port*3 +: 3]   = typ;
    rd_req[port]           = 1'b1;
    n = 0;
    do begin @(negedge aclk); #1; n++; end while (arvalid !== 1'b1 && n < 10);
    check("ar arvalid", arvalid, 1);
    check("ar arid", arid, 64'(port));
    check("ar araddr", araddr, addr);
    check("ar arlen", arlen, exp_len);
    arready = 1'b1;
    #1;
    check("ar rd_rdy pulse", rd_rdy, 64'(1 << port));
    rd_req[port] = 1'b0;
    @(negedge aclk);
    arready = 1'b0;
    #1;
    check("ar rd_rdy after", rd_rdy, 0);
    check("ar arvalid after", arvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hs;

    rv[0] = '{1'b1, 4'd0, 32'hA0A0_0001, 1'b0, 2'b01, 2'b00, 1'b1};
    rv[1] = '{1'b1, 4'd0, 32'hB0B0_0002, 1'b0, 2'b01, 2'b00, 1'b1};
    rv[2] = '{1'b1, 4'd1, 32'hE0E0_0005, 1'b1, 2'b10, 2'b10, 1'b1};
    rv[3] = '{1'b1, 4'd0, 32'hC0C0_0003, 1'b0, 2'b01, 2'b00, 1'b1};
    rv[4] = '{1'b1, 4'd0, 32'hD0D0_0004, 1'b1, 2'b01, 2'b01, 1'b1};
    rv[5] = '{1'b1, 4'd0, 32'hF0F0_0006, 1'b1, 2'b00, 2'b00, 1'b0};

    areset = 1'b1;
    rd_req = '0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

    // Reset state
    @(negedge aclk); #1;
    check("rst arvalid", arvalid, 0);
    check("rst awvalid", awvalid, 0);
    check("rst wvalid", wvalid, 0);
    check("rst rready", rready, 0);
    check("rst bready", bready, 0);
    check("rst wr_rdy", wr_rdy, 1);
    check("rst wr_done", wr_done, 0);
    check("rst araddr", araddr, 0);
    check("rst arlen", arlen, 0);
    check("rst arsize", arsize, 3'b010);
    check("rst arburst", arburst, 2'b01);
    check("rst awsize", awsize, 3'b010);
    @(negedge aclk);
    areset = 1'b0;

    // Line read on port0, single read on port1, then interleaved R beats from the table
    issue_ar(0, 32'h0000_1000, 3'b100, 4'd3);
    issue_ar(1, 32'h0000_1100, 3'b000, 4'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      rvalid = rv[k].rvalid; rid = rv[k].rid; rdata = rv[k].rdata; rlast = rv[k].rlast;
      #1;
      check("tbl ret_valid", ret_valid, rv[k].exp_valid);
      check("tbl ret_last", ret_last, rv[k].exp_last);
      check("tbl rready", rready, rv[k].exp_rready);
      check("tbl ret_data", ret_data, rv[k].rdata);
    end
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;

    // Round-robin alternation with both ports requesting continuously
    rd_addr = {32'h0000_5000, 32'h0000_4000};
    rd_type = '0;
    rd_req  = 2'b11;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge aclk); #1; n++; end while (arvalid !== 1'b1 && n < 10);
      check("rr arid", arid, 64'(k % 2));
      check("rr araddr", araddr, (k % 2) ? 32'h0000_5000 : 32'h0000_4000);
      if (k > 0) check("rr spacing", n, 2);
      if (k == 3) rd_req = 2'b00;
    end
    @(negedge aclk);
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("rr drained rready", rready, 0);

    // Outstanding limit: third AR waits for the first rlast
    rd_addr[31:0] = 32'h0000_6000;
    rd_type       = '0;
    rd_req        = 2'b01;
    arready       = 1'b1;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk); #1;
      if (arvalid && arready) hs++;
    end
    check("max_out handshakes", hs, 2);
    check("max_out rready", rready, 1);
    @(negedge aclk);
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; rdata = 32'h1111_2222;
    #1;
    check("max_out no ar at rlast", arvalid, 0);
    check("max_out ret_last", ret_last, 2'b01);
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("max_out grant cycle", arvalid, 0);
    @(negedge aclk); #1;
    check("max_out third ar", arvalid, 1);
    rd_req = 2'b00;
    @(negedge aclk);
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rid = 4'd0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge aclk);
      #1;
      check("max_out drain ret_valid", ret_valid, 2'b01);
    end
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("max_out drained rready", rready, 0);

    // Line write: W beats first, AW held off 5 cycles
    @(negedge aclk);
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_2000; wr_wstrb = 4'h3;
    wr_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    wready = 1'b1; awready = 1'b0;
    #1;
    check("wr accept rdy", wr_rdy, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      wr_req = 1'b0;
      #1;
      check("wline wvalid", wvalid, 1);
      check("wline wdata", wdata, (k == 0) ? 32'h0000_0000 : (32'h1111_0000 * k) + k);
      check("wline wlast", wlast, (k == 3) ? 1 : 0);
      check("wline wstrb", wstrb, 4'hf);
      check("wline awvalid", awvalid, 1);
    end
    @(negedge aclk); #1;
    check("wline w done wvalid", wvalid, 0);
    check("wline aw waiting", awvalid, 1);
    check("wline no bready yet", bready, 0);
    @(negedge aclk);
    awready = 1'b1;
    #1;
    check("wline awaddr", awaddr, 32'h0000_2000);
    check("wline awlen", awlen, 4'd3);
    @(negedge aclk);
    awready = 1'b0;
    #1;
    check("wline awvalid drop", awvalid, 0);
    check("wline bready", bready, 1);
    check("wline wr_done idle", wr_done, 0);
    @(negedge aclk);
    bvalid = 1'b1;
    #1;
    check("wline wr_done pulse", wr_done, 1);
    @(negedge aclk);
    bvalid = 1'b0; wready = 1'b0;
    #1;
    check("wline wr_done end", wr_done, 0);
    check("wline wr_rdy back", wr_rdy, 1);

    // Hazard: read of the written line waits for B; other line proceeds with the write accept
    @(negedge aclk);
    wr_req = 1'b1; wr_type = 3'b000; wr_addr = 32'h0000_2000; wr_wstrb = 4'h3;
    wr_data = {96'h0, 32'h1234_5678};
    rd_addr = {32'h0000_3000, 32'h0000_2008};
    rd_type = '0;
    rd_req  = 2'b11;
    awready = 1'b1; wready = 1'b0; arready = 1'b0;
    #1;
    check("hz wr_rdy", wr_rdy, 1);
    @(negedge aclk);
    wr_req = 1'b0;
    #1;
    check("hz awvalid", awvalid, 1);
    check("hz wvalid", wvalid, 1);
    check("hz single wstrb", wstrb, 4'h3);
    check("hz single wlast", wlast, 1);
    check("hz single awlen", awlen, 0);
    check("hz wdata", wdata, 32'h1234_5678);
    check("hz other line ar", arvalid, 1);
    check("hz other line arid", arid, 1);
    check("hz other line araddr", araddr, 32'h0000_3000);
    arready = 1'b1;
    rd_req[1] = 1'b0;
    #1;
    check("hz rd_rdy port1", rd_rdy, 2'b10);
    @(negedge aclk); #1;
    check("hz aw done first", awvalid, 0);
    check("hz w still valid", wvalid, 1);
    check("hz blocked 0", arvalid, 0);
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    #1;
    check("hz wvalid drop", wvalid, 0);
    check("hz bready", bready, 1);
    check("hz blocked 1", arvalid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk); #1;
      check("hz blocked wait", arvalid, 0);
    end
    @(negedge aclk);
    bvalid = 1'b1;
    #1;
    check("hz wr_done", wr_done, 1);
    check("hz blocked at b", arvalid, 0);
    @(negedge aclk);
    bvalid = 1'b0;
    #1;
    check("hz grant cycle", arvalid, 0);
    check("hz wr_rdy", wr_rdy, 1);
    @(negedge aclk); #1;
    check("hz ar released", arvalid, 1);
    check("hz released arid", arid, 0);
    check("hz released araddr", araddr, 32'h0000_2008);
    check("hz released rd_rdy", rd_rdy, 2'b01);
    rd_req = 2'b00;
    @(negedge aclk);
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rid = 4'd1;
    #1;
    check("hz ret port1", ret_valid, 2'b10);
    @(negedge aclk);
    rid = 4'd0;
    #1;
    check("hz ret port0", ret_valid, 2'b01);
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("hz drained rready", rready, 0);

    // Reset in the middle of a read burst, a pending AR and a pending write
    issue_ar(0, 32'h0000_7000, 3'b100, 4'd3);
    @(negedge aclk);
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b0; rdata = 32'h7777_0000;
    rd_addr[63:32] = 32'h0000_8000; rd_type[5:3] = 3'b000; rd_req = 2'b10;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_9000;
    awready = 1'b0; wready = 1'b0;
    @(negedge aclk);
    wr_req = 1'b0;
    #1;
    check("mid arvalid", arvalid, 1);
    check("mid wvalid", wvalid, 1);
    check("mid rready", rready, 1);
    check("mid ret_valid", ret_valid, 2'b01);
    #2;
    areset = 1'b1;
    #1;
    check("arst arvalid", arvalid, 0);
    check("arst awvalid", awvalid, 0);
    check("arst wvalid", wvalid, 0);
    check("arst rready", rready, 0);
    check("arst bready", bready, 0);
    check("arst wr_rdy", wr_rdy, 1);
    check("arst ret_valid", ret_valid, 0);
    @(negedge aclk);
    rd_req = 2'b00; rvalid = 1'b0;
    areset = 1'b0;
    @(negedge aclk); #1;
    check("post rst rready", rready, 0);
    check("post rst arvalid", arvalid, 0);
    check("post rst wr_rdy", wr_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
